spi_master_out: RTL and testbench

SPI master transmitter (output only) that serialises a parallel word onto cs/sck/mosi for our SPI input slave. It sits in the host-side or test-harness domain and drives the PID parameter-load link. It generates SCK from clk by integer division, shifts the word MSB-first, and frames it with cs. It applies the link's inverted-MOSI line convention, under which the slave stores !mosi.

---
 rtl/spi_pkg.sv | 24 ++
 rtl/spi_half_period_timer.sv | 29 ++
 rtl/spi_master_out.sv | 130 +++++++++++++
 tb/tb_spi_master_out.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI link definitions: FSM states,
// line polarity and default word width.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCK_HI,
    SCK_LO,
    HOLD,
    DONE
  } state_t;

  // Link polarity shared with the slave: it stores !mosi.
  localparam logic MOSI_INVERT = 1'b1;

  localparam int DEF_BITS = 32;

  // Map a data bit to its level on the mosi wire.
  function automatic logic line_bit(input logic b);
    return b ^ MOSI_INVERT;
  endfunction

endpackage

// File: rtl/spi_half_period_timer.sv
// SCK half-period divider: counts 0..CLK_DIV-1,
// ticks on the terminal count, held at 0 by clear.
module spi_half_period_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int DW = $clog2(CLK_DIV);

  logic [DW-1:0] cnt;

  assign tick = (cnt == DW'(CLK_DIV - 1));

  // Free-run while active, wrap on tick, hold at 0 when cleared.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_out.sv
// SPI master transmitter: MSB-first word on
// cs/sck/mosi with inverted mosi line polarity.
module spi_master_out
  import spi_pkg::*;
#(
  parameter int BITS    = DEF_BITS,
  parameter int CLK_DIV = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [BITS-1:0] data_in,
  output logic            busy,
  output logic            done,
  output logic            cs,
  output logic            sck,
  output logic            mosi
);

  localparam int CW = $clog2(BITS + 1);
  localparam logic [CW-1:0] BITS_C = CW'(BITS);

  state_t          state, state_n;
  logic [BITS-1:0] sh, sh_n;
  logic [CW-1:0]   bit_cnt, bit_n;
  logic            cs_n, sck_n, mosi_n;
  logic            busy_n, done_n;
  logic            tick, clear;

  assign clear = (state == IDLE) || (state == DONE);

  spi_half_period_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .clear(clear),
    .tick (tick)
  );

  // State, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      sh      <= '0;
      bit_cnt <= '0;
      cs      <= 1'b1;
      sck     <= 1'b0;
      mosi    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      sh      <= sh_n;
      bit_cnt <= bit_n;
      cs      <= cs_n;
      sck     <= sck_n;
      mosi    <= mosi_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

  // Next state and next output values.
  always_comb begin
    state_n = state;
    sh_n    = sh;
    bit_n   = bit_cnt;
    cs_n    = cs;
    sck_n   = sck;
    mosi_n  = mosi;
    busy_n  = busy;
    done_n  = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = SETUP;
          sh_n    = data_in;
          bit_n   = '0;
          cs_n    = 1'b0;
          sck_n   = 1'b0;
          mosi_n  = line_bit(data_in[BITS-1]);
          busy_n  = 1'b1;
        end else begin
          state_n = IDLE;
          cs_n    = 1'b1;
          sck_n   = 1'b0;
          mosi_n  = 1'b1;
          busy_n  = 1'b0;
        end
      end
      SETUP: begin
        if (tick) begin
          state_n = SCK_HI;
          sck_n   = 1'b1;
        end
      end
      SCK_HI: begin
        if (tick) begin
          state_n = SCK_LO;
          sck_n   = 1'b0;
        end
      end
      SCK_LO: begin
        if (tick) begin
          bit_n = bit_cnt + 1'b1;
          if (bit_n == BITS_C) begin
            state_n = HOLD;
          end else begin
            state_n = SCK_HI;
            sh_n    = sh << 1;
            mosi_n  = line_bit(sh[BITS-2]);
            sck_n   = 1'b1;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          state_n = DONE;
          cs_n    = 1'b1;
          mosi_n  = 1'b1;
          done_n  = 1'b1;
          busy_n  = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_master_out.sv
// Bench for spi_master_out with a behavioural
// slave model and scoreboard queues.
module tb_spi_master_out;

  logic clk = 1'b0;
  logic reset;
  logic start, start2;
  logic [31:0] data_in;
  logic [7:0]  data2;
  logic busy, done, cs, sck, mosi;
  logic busy2, done2, cs2, sck2, mosi2;

  always #5 clk = ~clk;

  spi_master_out #(.BITS(32), .CLK_DIV(4)) dut (
    .clk(clk), .reset(reset), .start(start),
    .data_in(data_in), .busy(busy), .done(done),
    .cs(cs), .sck(sck), .mosi(mosi)
  );

  spi_master_out #(.BITS(8), .CLK_DIV(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2),
    .data_in(data2), .busy(busy2), .done(done2),
    .cs(cs2), .sck(sck2), .mosi(mosi2)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  logic [31:0] q[$];
  logic [7:0]  q2[$];

  // Slave model and monitor for the 32-bit instance.
  logic [31:0] rx;
  logic        fall_mosi [32];
  int falls = 0, last_falls = 0;
  int last_fall = -100, last_chg = -100;
  int stab_err = 0, idle_err = 0;
  int busy_cyc = 0, len = 0, done_cnt = 0;
  int hi_run = 0, last_gap = 0;
  logic p_cs = 1'b1, p_sck = 1'b0;
  logic p_mosi = 1'b1, p_busy = 1'b0;

  always @(negedge clk) begin
    if (!cs && p_cs) begin
      falls    = 0;
      rx       = '0;
      last_gap = hi_run;
    end
    if (cs) hi_run++;
    else    hi_run = 0;
    if (!cs && p_sck && !sck) begin
      if (falls < 32) fall_mosi[falls] = mosi;
      rx = {rx[30:0], ~mosi};
      falls++;
      if (cyc - last_chg < 4) stab_err++;
      last_fall = cyc;
    end
    if (mosi !== p_mosi) begin
      if (!cs && !p_cs && (cyc - last_fall < 4))
        stab_err++;
      last_chg = cyc;
    end
    if (cs && p_cs && (sck !== p_sck)) idle_err++;
    if (cs && !p_cs) begin
      last_falls = falls;
      if (falls == 32) begin
        if (q.size() == 0) chk("sb_empty", 1, 0);
        else chk("rx_word", rx, q.pop_front());
      end
    end
    if (busy && !p_busy) busy_cyc = cyc;
    if (done) begin
      done_cnt++;
      len = cyc - busy_cyc;
    end
    p_cs   = cs;
    p_sck  = sck;
    p_mosi = mosi;
    p_busy = busy;
  end

  // Slave model and monitor for the 8-bit instance.
  logic [7:0] rx2;
  int falls2 = 0, busy_cyc2 = 0, len2 = 0;
  logic p_cs2 = 1'b1, p_sck2 = 1'b0, p_busy2 = 1'b0;

  always @(negedge clk) begin
    if (!cs2 && p_cs2) begin
      falls2 = 0;
      rx2    = '0;
    end
    if (!cs2 && p_sck2 && !sck2) begin
      rx2 = {rx2[6:0], ~mosi2};
      falls2++;
    end
    if (cs2 && !p_cs2 && falls2 == 8) begin
      if (q2.size() == 0) chk("sb2_empty", 1, 0);
      else chk("rx2_word", {24'h0, rx2}, {24'h0, q2.pop_front()});
    end
    if (busy2 && !p_busy2) busy_cyc2 = cyc;
    if (done2) len2 = cyc - busy_cyc2;
    p_cs2   = cs2;
    p_sck2  = sck2;
    p_busy2 = busy2;
  end

  task automatic send(input logic [31:0] w);
    data_in = w;
    start   = 1'b1;
    q.push_back(w);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input int budget);
    int n = 0;
    while (((sel ? done2 : done) !== 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", {31'h0, sel ? done2 : done}, 1);
    @(negedge clk);
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    start2  = 1'b0;
    data_in = '0;
    data2   = '0;
    repeat (3) @(negedge clk);
    chk("rst_cs",   {31'h0, cs},   1);
    chk("rst_sck",  {31'h0, sck},  0);
    chk("rst_mosi", {31'h0, mosi}, 1);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_done", {31'h0, done}, 0);
    chk("rst_cs2",  {31'h0, cs2},  1);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Basic word, length and edge count.
    done_cnt = 0;
    send(32'hA5A50F3C);
    chk("busy_up", {31'h0, busy}, 1);
    wait_done(1'b0, 400);
    chk("len32", len, 264);
    chk("falls32", last_falls, 32);
    chk("done_cnt1", done_cnt, 1);
    chk("sb_drain1", q.size(), 0);

    // Waveform of 0x80000001.
    stab_err = 0;
    send(32'h80000001);
    wait_done(1'b0, 400);
    for (int i = 0; i < 32; i++)
      chk($sformatf("mosi_fall%0d", i),
          {31'h0, fall_mosi[i]},
          (i == 0 || i == 31) ? 0 : 1);
    chk("mosi_stable", stab_err, 0);
    chk("idle_sck", idle_err, 0);

    // start during transfer is ignored.
    done_cnt = 0;
    send(32'h0F0F1234);
    repeat (100) @(negedge clk);
    data_in = 32'hFFFFFFFF;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b0, 400);
    repeat (5) @(negedge clk);
    chk("ign_done_cnt", done_cnt, 1);
    chk("sb_drain3", q.size(), 0);

    // Reset near bit 10.
    done_cnt = 0;
    send(32'hDEADBEEF);
    for (int n = 0; n < 400 && falls < 10; n++)
      @(negedge clk);
    chk("reached_bit10", {31'h0, falls >= 10}, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_cs",   {31'h0, cs},   1);
    chk("mid_sck",  {31'h0, sck},  0);
    chk("mid_mosi", {31'h0, mosi}, 1);
    chk("mid_busy", {31'h0, busy}, 0);
    chk("mid_done", {31'h0, done}, 0);
    reset = 1'b0;
    void'(q.pop_front());
    repeat (4) @(negedge clk);
    chk("mid_no_done", done_cnt, 0);
    send(32'h12345678);
    wait_done(1'b0, 400);
    chk("sb_drain4", q.size(), 0);

    // Back-to-back words.
    data_in = 32'h0;
    start   = 1'b1;
    q.push_back(32'h0);
    q.push_back(32'hFFFFFFFF);
    @(negedge clk);
    data_in = 32'hFFFFFFFF;
    wait_done(1'b0, 400);
    start = 1'b0;
    chk("b2b_busy", {31'h0, busy}, 1);
    wait_done(1'b0, 400);
    chk("b2b_gap", last_gap, 1);
    chk("sb_drain5", q.size(), 0);

    // 8-bit, divide-by-2 instance.
    data2  = 8'h3C;
    start2 = 1'b1;
    q2.push_back(8'h3C);
    @(negedge clk);
    start2 = 1'b0;
    wait_done(1'b1, 100);
    chk("len8", len2, 36);
    chk("sb2_drain", q2.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
